// File: rtl/jump_window_ctrl.sv
// Per-channel jump FSMs (IDLE -> AIR -> COOL) gated by a shared periodic jump window.
// Define JUMP_QUEUE_EN to hold requests made while the window is closed until it reopens.
module jump_window_ctrl #(
    parameter int CHANNELS   = 2,
    parameter int PERIOD     = 6,
    parameter int WINDOW     = 3,
    parameter int AIR_TICKS  = 8,
    parameter int COOL_TICKS = 4
) (
    input  logic                proc_clk,
    input  logic                reset,
    input  logic                en,
    input  logic                frame_tick,
    input  logic [CHANNELS-1:0] jump_req,
    input  logic [CHANNELS-1:0] ground_hit,
    output logic [CHANNELS-1:0] can_jump,
    output logic [CHANNELS-1:0] jump_grant,
    output logic [CHANNELS-1:0] airborne,
    output logic                any_airborne
);

    localparam int PHASE_W   = $clog2(PERIOD);
    localparam int MAX_TICKS = (AIR_TICKS > COOL_TICKS) ? AIR_TICKS : COOL_TICKS;
    localparam int CNT_W     = $clog2(MAX_TICKS + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AIR  = 2'd1,
        COOL = 2'd2
    } chan_state_e;

    // With no cooldown configured a landing goes straight back to IDLE.
    localparam chan_state_e        LANDED     = (COOL_TICKS == 0) ? IDLE : COOL;
    localparam logic [PHASE_W-1:0] PHASE_LAST = PHASE_W'(PERIOD - 1);
    localparam logic [CNT_W-1:0]   AIR_LAST   = CNT_W'(AIR_TICKS - 1);
    localparam logic [CNT_W-1:0]   COOL_LAST  = CNT_W'((COOL_TICKS > 0) ? COOL_TICKS - 1 : 0);

    logic [PHASE_W-1:0]  phase_q;
    logic                window_open;
    chan_state_e         state_q [CHANNELS];
    chan_state_e         state_d [CHANNELS];
    logic [CNT_W-1:0]    count_q [CHANNELS];
    logic [CNT_W-1:0]    count_d [CHANNELS];
    logic [CHANNELS-1:0] grant_set;
    logic [CHANNELS-1:0] grant_q;
`ifdef JUMP_QUEUE_EN
    logic [CHANNELS-1:0] pending_q;
    logic                phase_zero;
`endif

    if (WINDOW >= PERIOD) begin : g_always_open
        assign window_open = 1'b1;
    end else begin : g_window
        assign window_open = (phase_q < PHASE_W'(WINDOW));
    end

    always_ff @(posedge proc_clk) begin
        if (reset) begin
            phase_q <= '0;
            grant_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                state_q[i] <= IDLE;
                count_q[i] <= '0;
            end
        end else begin
            grant_q <= grant_set;
            if (en) begin
                phase_q <= (phase_q == PHASE_LAST) ? '0 : phase_q + PHASE_W'(1);
                state_q <= state_d;
                count_q <= count_d;
            end
        end
    end

    // A final AIR tick and a ground hit in the same cycle collapse into one landing.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            state_d[i] = state_q[i];
            count_d[i] = count_q[i];
            if (en) begin
                case (state_q[i])
                    IDLE: begin
                        if (grant_set[i]) begin
                            state_d[i] = AIR;
                            count_d[i] = '0;
                        end
                    end
                    AIR: begin
                        if (ground_hit[i] || (frame_tick && count_q[i] == AIR_LAST)) begin
                            state_d[i] = LANDED;
                            count_d[i] = '0;
                        end else if (frame_tick) begin
                            count_d[i] = count_q[i] + CNT_W'(1);
                        end
                    end
                    COOL: begin
                        if (frame_tick) begin
                            if (count_q[i] == COOL_LAST) begin
                                state_d[i] = IDLE;
                                count_d[i] = '0;
                            end else begin
                                count_d[i] = count_q[i] + CNT_W'(1);
                            end
                        end
                    end
                    default: begin
                        state_d[i] = IDLE;
                        count_d[i] = '0;
                    end
                endcase
            end
        end
    end

    always_comb begin
        can_jump  = '0;
        airborne  = '0;
        grant_set = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            can_jump[i] = window_open && (state_q[i] == IDLE);
            airborne[i] = (state_q[i] == AIR);
`ifdef JUMP_QUEUE_EN
            grant_set[i] = en && can_jump[i] && (jump_req[i] || (pending_q[i] && phase_zero));
`else
            grant_set[i] = en && can_jump[i] && jump_req[i];
`endif
        end
    end

    assign any_airborne = |airborne;
    assign jump_grant   = grant_q & {CHANNELS{en}};

`ifdef JUMP_QUEUE_EN
    assign phase_zero = (phase_q == '0);

    // Only idle channels queue; any grant consumes the pending request.
    always_ff @(posedge proc_clk) begin
        if (reset) begin
            pending_q <= '0;
        end else if (en) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (grant_set[i]) begin
                    pending_q[i] <= 1'b0;
                end else if (state_q[i] == IDLE && !window_open && jump_req[i]) begin
                    pending_q[i] <= 1'b1;
                end
            end
        end
    end
`endif

endmodule

// File: doc/jump_window_ctrl.md
JUMP_WINDOW_CTRL -- requirements
Module: jump_window_ctrl

Interface
REQ-001 Parameter CHANNELS, default 2, number of independent jump channels (players), 1..8.
REQ-002 Parameter PERIOD, default 6, length in proc_clk cycles of the shared jump-window cycle, >=2.
REQ-003 Parameter WINDOW, default 3, open cycles per period, 1..PERIOD.
REQ-004 Parameter AIR_TICKS, default 8, frame_tick pulses a channel stays airborne, >=1.
REQ-005 Parameter COOL_TICKS, default 4, frame_tick pulses of post-landing cooldown, >=0.
REQ-006 proc_clk  input  1  sole clock; all state updates on rising edge.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 en  input  1  global enable; 0 freezes all state.
REQ-009 frame_tick  input  1  one-cycle frame-rate strobe.
REQ-010 jump_req  input  CHANNELS  per-channel jump request, level sampled each cycle.
REQ-011 ground_hit  input  CHANNELS  per-channel landing indication from collision logic.
REQ-012 can_jump  output  CHANNELS  channel idle and window open.
REQ-013 jump_grant  output  CHANNELS  one-cycle pulse when a jump is accepted.
REQ-014 airborne  output  CHANNELS  channel in AIR state.
REQ-015 any_airborne  output  1  OR of airborne.

Function
REQ-016 Shared phase counter (width clog2(PERIOD)) SHALL increment each cycle with en=1 and wrap PERIOD-1 -> 0.
REQ-017 window_open SHALL equal (phase < WINDOW), decoded from registered phase, zero added latency.
REQ-018 Each channel SHALL run an FSM IDLE -> AIR -> COOL -> IDLE, with a tick counter sized for max(AIR_TICKS, COOL_TICKS).
REQ-019 can_jump[i] SHALL be window_open AND state[i]==IDLE.
REQ-020 jump_req[i]=1 in a cycle with can_jump[i]=1 SHALL move channel i to AIR and assert jump_grant[i] for exactly the next cycle; tick counter cleared.
REQ-021 In AIR, airborne[i]=1; each frame_tick increments the counter; on the AIR_TICKS-th tick the channel SHALL enter COOL (or IDLE when COOL_TICKS=0).
REQ-022 ground_hit[i]=1 in AIR SHALL end AIR next cycle, same destination as REQ-021; ground_hit outside AIR ignored.
REQ-023 Final AIR tick coincident with ground_hit SHALL produce a single transition, counter cleared once.
REQ-024 In COOL, on the COOL_TICKS-th frame_tick the channel SHALL return to IDLE; jump_req ignored.
REQ-025 A held jump_req SHALL re-trigger only after the channel returns to IDLE and the window is open (no edge detection).
REQ-026 Channels SHALL be fully independent; simultaneous grants on several channels allowed in one cycle.
REQ-027 en=0 SHALL hold phase, FSMs, counters and pending bits; jump_grant forced 0; frame_tick and requests ignored.

Reset
REQ-028 reset=1 at a rising edge SHALL set phase=0, all FSMs IDLE, counters 0, pending 0, regardless of en.
REQ-029 Outputs after reset: jump_grant=0, airborne=0, any_airborne=0, can_jump=all ones (phase 0 inside window).
REQ-030 Reset mid-AIR SHALL abort the jump with no grant or cooldown.

Configuration
REQ-031 Macro JUMP_QUEUE_EN defined: jump_req[i] in IDLE with window closed SHALL set pending[i]; at the first cycle of the next open window (phase==0) a still-IDLE channel with pending[i] SHALL be granted as in REQ-020 and pending[i] cleared.
REQ-032 JUMP_QUEUE_EN defined: requests in AIR or COOL SHALL NOT set pending; a grant via REQ-020 also clears pending.
REQ-033 JUMP_QUEUE_EN undefined: requests with window closed dropped; no pending storage synthesised.

Verification
REQ-034 Reset, en=1, defaults, no requests -> can_jump=2'b11 in phases 0-2, 2'b00 in phases 3-5, period 6 cycles repeating.
REQ-035 jump_req[0] pulse at phase 1 -> jump_grant[0] next cycle only, airborne[0]=1 for 8 frame_ticks, can_jump[0]=0 through 4 cooldown ticks.
REQ-036 ground_hit[1] after 3 ticks airborne, and separately ground_hit coincident with 8th tick -> single entry to COOL, then IDLE after 4 ticks.
REQ-037 Both channels request same cycle in window -> jump_grant=2'b11 same cycle; en=0 for 5 cycles mid-AIR -> phase and tick counts unchanged.
REQ-038 JUMP_QUEUE_EN: jump_req[0] pulse at phase 4 -> grant in cycle after next phase 0; without macro -> no grant.
REQ-039 reset asserted mid-AIR -> next cycle airborne=0, can_jump=2'b11, no jump_grant.
